forward_sequencer: RTL

//  Controller for one forward pass of the neuron array. Fetches operand pairs from the

---
 rtl/fwd_pkg.sv | 24 ++
 rtl/fwd_delay_line.sv | 39 +++
 rtl/forward_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the forward-pass sequencer: default widths, latencies,
// the FSM state encoding and the drain-length helper.
package fwd_pkg;

    localparam int AWIDTH_DEF   = 8;
    localparam int CWIDTH_DEF   = 8;
    localparam int RD_LAT_DEF   = 1;
    localparam int PIPE_LAT_DEF = 2;
    localparam int DRAIN_LEN    = RD_LAT_DEF + PIPE_LAT_DEF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    function automatic int drain_len(input int rd_lat, input int pipe_lat);
        return rd_lat + pipe_lat;
    endfunction

endpackage

// File: rtl/fwd_delay_line.sv
// Single-bit shift register of DEPTH stages with asynchronous active-low clear;
// DEPTH=0 degenerates to a wire.
module fwd_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_shift
            logic [DEPTH-1:0] stage_q;
            logic [DEPTH-1:0] stage_d;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    assign stage_d[gi] = d_i;
                end else begin : g_next
                    assign stage_d[gi] = stage_q[gi-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/forward_sequencer.sv
// Forward-pass controller: clears accumulators, streams operand-pair reads, waits out
// the read and array latency, then writes each neuron's out1/out2 pair.
module forward_sequencer
    import fwd_pkg::*;
#(
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int CWIDTH   = CWIDTH_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CWIDTH-1:0] num_pairs,
    input  logic [CWIDTH-1:0] num_neurons,
    input  logic [AWIDTH-1:0] rd_base,
    input  logic [AWIDTH-1:0] wr_base,
    output logic [AWIDTH-1:0] addread1,
    output logic [AWIDTH-1:0] addread2,
    output logic              rd_en,
    output logic              acc_clr,
    output logic              acc_en,
    output logic [AWIDTH-1:0] addwrite1,
    output logic [AWIDTH-1:0] addwrite2,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    localparam int               DRAIN_CYC = drain_len(RD_LAT, PIPE_LAT);
    localparam logic [CWIDTH-1:0] DRAIN_CNT = CWIDTH'(DRAIN_CYC);
    localparam logic [CWIDTH-1:0] CNT_ONE   = CWIDTH'(1);

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [CWIDTH-1:0] n_q, n_d;
    logic [CWIDTH-1:0] nrem_q, nrem_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;

    logic [AWIDTH-1:0] addread1_q, addread1_d;
    logic [AWIDTH-1:0] addread2_q, addread2_d;
    logic [AWIDTH-1:0] addwrite1_q, addwrite1_d;
    logic [AWIDTH-1:0] addwrite2_q, addwrite2_d;
    logic              rd_en_q, rd_en_d;
    logic              acc_clr_q, acc_clr_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next state plus the registered outputs that belong to the state being entered,
    // so every strobe is valid in the same cycle its state is current.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        nrem_d      = nrem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        addread1_d  = addread1_q;
        addread2_d  = addread2_q;
        addwrite1_d = addwrite1_q;
        addwrite2_d = addwrite2_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d      = num_pairs;
                    nrem_d   = num_neurons;
                    rd_ptr_d = rd_base;
                    wr_ptr_d = wr_base;
                    state_d  = (num_neurons != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                if (n_q != '0) begin
                    state_d = S_FETCH;
                    cnt_d   = n_q;
                end else begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_CNT;
                end
            end
            S_FETCH: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_CNT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            // nrem was already decremented on entry to WRITE
            S_WRITE: state_d = (nrem_q != '0) ? S_CLEAR : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_FETCH) begin
            rd_en_d    = 1'b1;
            addread1_d = rd_ptr_q;
            addread2_d = rd_ptr_q + AWIDTH'(1);
            rd_ptr_d   = rd_ptr_q + AWIDTH'(2);
        end

        if (state_d == S_WRITE) begin
            wr_en_d     = 1'b1;
            addwrite1_d = wr_ptr_q;
            addwrite2_d = wr_ptr_q + AWIDTH'(1);
            wr_ptr_d    = wr_ptr_q + AWIDTH'(2);
            nrem_d      = nrem_q - CNT_ONE;
        end

        acc_clr_d = (state_d == S_CLEAR);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            nrem_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            addread1_q  <= '0;
            addread2_q  <= '0;
            addwrite1_q <= '0;
            addwrite2_q <= '0;
            rd_en_q     <= 1'b0;
            acc_clr_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            nrem_q      <= nrem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            addread1_q  <= addread1_d;
            addread2_q  <= addread2_d;
            addwrite1_q <= addwrite1_d;
            addwrite2_q <= addwrite2_d;
            rd_en_q     <= rd_en_d;
            acc_clr_q   <= acc_clr_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // acc_en trails rd_en by the read latency so it lands with A/B
    fwd_delay_line #(
        .DEPTH(RD_LAT)
    ) u_acc_dly (
        .clk  (clk),
        .rst_n(rst),
        .d_i  (rd_en_q),
        .q_o  (acc_en)
    );

    assign addread1  = addread1_q;
    assign addread2  = addread2_q;
    assign rd_en     = rd_en_q;
    assign acc_clr   = acc_clr_q;
    assign addwrite1 = addwrite1_q;
    assign addwrite2 = addwrite2_q;
    assign wr_en     = wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
